serial_adder: RTL and testbench

SERIAL_ADDER -- requirements
Module: serial_adder

---
 rtl/serial_adder_pkg.sv | 18 +
 rtl/serial_adder_fa.sv | 19 +
 rtl/serial_adder.sv | 118 +++++++++++
 tb/tb_serial_adder.sv | 199 +++++++++++++++++++
 4 files changed

// File: rtl/serial_adder_pkg.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder_pkg
// Purpose  : Shared state encodings and defaults for the bit-serial adder.
// Revision : 1.0  initial release
// ============================================================================
package serial_adder_pkg;

    localparam int c_default_width = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/serial_adder_fa.sv
`default_nettype none
// ============================================================================
// Module   : fa_dataflow
// Purpose  : 1-bit full-adder cell (sum and carry-out of a + b + ci).
// Revision : 1.0  initial release
// ============================================================================
module fa_dataflow (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule
`default_nettype wire

// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : serial_adder
// Purpose  : Bit-serial adder, {co,s} = a + b + ci, LSB first, one bit/clock.
// Revision : 1.0  initial release
// ============================================================================
module serial_adder
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = c_default_width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int                 c_cnt_w    = $clog2(WIDTH + 1);
    localparam logic [c_cnt_w-1:0] c_last_bit = c_cnt_w'(WIDTH - 1);

    state_t             r_state;
    state_t             w_state_next;
    logic [WIDTH-1:0]   r_a_sr;
    logic [WIDTH-1:0]   r_b_sr;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_s;
    logic               r_carry;
    logic               r_co;
    logic [c_cnt_w-1:0] r_cnt;

    logic               w_sum;
    logic               w_cout;
    logic               w_last;
    logic [WIDTH-1:0]   w_acc_next;
    logic               w_unused_acc_lsb;

    fa_dataflow u_fa (
        .s  (w_sum),
        .co (w_cout),
        .a  (r_a_sr[0]),
        .b  (r_b_sr[0]),
        .ci (r_carry)
    );

    // The sum bit enters at the MSB; the oldest accumulator bit falls off.
    generate
        if (WIDTH == 1) begin : g_acc_w1
            assign w_acc_next = w_sum;
        end else begin : g_acc_wn
            assign w_acc_next = {w_sum, r_acc[WIDTH-1:1]};
        end
    endgenerate

    assign w_unused_acc_lsb = r_acc[0];
    assign w_last           = (r_cnt == c_last_bit);

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (start)  w_state_next = RUN;
            RUN:     if (w_last) w_state_next = DONE;
            DONE:    w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
            r_a_sr  <= '0;
            r_b_sr  <= '0;
            r_acc   <= '0;
            r_s     <= '0;
            r_carry <= 1'b0;
            r_co    <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_a_sr  <= a;
                        r_b_sr  <= b;
                        r_carry <= ci;
                        r_acc   <= '0;
                        r_cnt   <= '0;
                    end
                end
                RUN: begin
                    r_acc   <= w_acc_next;
                    r_carry <= w_cout;
                    r_a_sr  <= r_a_sr >> 1;
                    r_b_sr  <= r_b_sr >> 1;
                    r_cnt   <= r_cnt + c_cnt_w'(1);
                    // Results are published only once the final bit is in.
                    if (w_last) begin
                        r_s  <= w_acc_next;
                        r_co <= w_cout;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state == RUN);
    assign done = (r_state == DONE);
    assign s    = r_s;
    assign co   = r_co;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_serial_adder
// Purpose  : Directed self-checking bench for serial_adder (WIDTH 8, 3, 1).
// Revision : 1.0  initial release
// ============================================================================
module tb_serial_adder;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [2:0]  start_v;
    logic [2:0]  ci_v;
    logic [31:0] a_v [3];
    logic [31:0] b_v [3];

    wire  [2:0]  busy_v;
    wire  [2:0]  done_v;
    wire  [2:0]  co_v;
    wire  [7:0]  s8;
    wire  [2:0]  s3;
    wire  [0:0]  s1;

    int          n_checks = 0;
    int          n_errors = 0;
    logic [31:0] prev_s  [3];
    logic        prev_co [3];

    serial_adder #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start_v[0]), .a(a_v[0][7:0]), .b(b_v[0][7:0]),
        .ci(ci_v[0]), .busy(busy_v[0]), .done(done_v[0]), .s(s8), .co(co_v[0])
    );

    serial_adder #(.WIDTH(3)) u_dut3 (
        .clk(clk), .rst(rst), .start(start_v[1]), .a(a_v[1][2:0]), .b(b_v[1][2:0]),
        .ci(ci_v[1]), .busy(busy_v[1]), .done(done_v[1]), .s(s3), .co(co_v[1])
    );

    serial_adder #(.WIDTH(1)) u_dut1 (
        .clk(clk), .rst(rst), .start(start_v[2]), .a(a_v[2][0:0]), .b(b_v[2][0:0]),
        .ci(ci_v[2]), .busy(busy_v[2]), .done(done_v[2]), .s(s1), .co(co_v[2])
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] s_of(input int d);
        case (d)
            0:       return {24'd0, s8};
            1:       return {29'd0, s3};
            default: return {31'd0, s1};
        endcase
    endfunction

    // One operation on DUT d; poke[n] re-raises start (with new operands) at
    // cycle n after E0, rst_at > 0 asserts reset at that RUN cycle.
    task automatic op(input int d, input int w, input logic [31:0] a, input logic [31:0] b,
                      input logic c, input logic [31:0] es, input logic ec,
                      input logic [15:0] poke, input int rst_at, input string tag);
        int busy_n  = 0;
        int done_n  = 0;
        int done_at = 0;
        int overlap = 0;
        int s_moved = 0;
        @(negedge clk);
        a_v[d] = a; b_v[d] = b; ci_v[d] = c; start_v[d] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= w + 4; n++) begin
            @(negedge clk);
            if (busy_v[d]) busy_n++;
            if (busy_v[d] && done_v[d]) overlap++;
            if (done_v[d]) begin
                done_n++;
                done_at = n;
                prev_s[d]  = es;
                prev_co[d] = ec;
            end
            if (s_of(d) !== prev_s[d] || co_v[d] !== prev_co[d]) s_moved++;
            if (n == rst_at) begin
                rst = 1'b1;
                for (int k = 0; k < 3; k++) begin
                    prev_s[k]  = '0;
                    prev_co[k] = 1'b0;
                end
            end else begin
                rst = 1'b0;
            end
            start_v[d] = poke[n];
            if (poke[n]) begin
                a_v[d]  = ~a_v[d];
                b_v[d]  = b_v[d] + 32'h33;
                ci_v[d] = ~ci_v[d];
            end
        end
        start_v[d] = 1'b0;
        rst        = 1'b0;
        check({tag, "/busy_cycles"}, busy_n, (rst_at > 0) ? rst_at : w);
        check({tag, "/done_pulses"}, done_n, (rst_at > 0) ? 0 : 1);
        if (rst_at == 0) check({tag, "/done_cycle"}, done_at, w + 1);
        check({tag, "/busy_and_done"}, overlap, 0);
        check({tag, "/s_unstable"}, s_moved, 0);
        check({tag, "/s"}, s_of(d), es);
        check({tag, "/co"}, {31'd0, co_v[d]}, {31'd0, ec});
    endtask

    task automatic back_to_back();
        logic [7:0] ta [3];
        logic [7:0] tb [3];
        logic       tc [3];
        logic [7:0] ts [3];
        logic       tco[3];
        int k         = 0;
        int last_done = 0;
        int s_moved   = 0;
        ta = '{8'h3C, 8'hFF, 8'h80};
        tb = '{8'h42, 8'h01, 8'h80};
        tc = '{1'b0,  1'b0,  1'b1};
        ts = '{8'h7E, 8'h00, 8'h01};
        tco = '{1'b0, 1'b1,  1'b1};
        @(negedge clk);
        a_v[0] = {24'd0, ta[0]}; b_v[0] = {24'd0, tb[0]}; ci_v[0] = tc[0];
        start_v[0] = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 40; n++) begin
            @(negedge clk);
            if (done_v[0] && k < 3) begin
                check($sformatf("b2b%0d/s", k), {24'd0, s8}, {24'd0, ts[k]});
                check($sformatf("b2b%0d/co", k), {31'd0, co_v[0]}, {31'd0, tco[k]});
                check($sformatf("b2b%0d/spacing", k), n - last_done, (k == 0) ? 9 : 10);
                check($sformatf("b2b%0d/busy_and_done", k), {31'd0, busy_v[0]}, 32'd0);
                last_done = n;
                prev_s[0]  = {24'd0, ts[k]};
                prev_co[0] = tco[k];
                k++;
                if (k < 3) begin
                    a_v[0] = {24'd0, ta[k]}; b_v[0] = {24'd0, tb[k]}; ci_v[0] = tc[k];
                end else begin
                    start_v[0] = 1'b0;
                end
            end
            if ({24'd0, s8} !== prev_s[0] || co_v[0] !== prev_co[0]) s_moved++;
        end
        start_v[0] = 1'b0;
        check("b2b/done_count", k, 3);
        check("b2b/s_unstable", s_moved, 0);
    endtask

    initial begin
        logic [6:0] v;
        logic [3:0] sum3;
        rst     = 1'b1;
        start_v = '0;
        ci_v    = '0;
        for (int k = 0; k < 3; k++) begin
            a_v[k]     = '0;
            b_v[k]     = '0;
            prev_s[k]  = '0;
            prev_co[k] = 1'b0;
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset/busy", {31'd0, busy_v[0]}, 32'd0);
        check("reset/done", {31'd0, done_v[0]}, 32'd0);
        check("reset/s", {24'd0, s8}, 32'd0);
        check("reset/co", {31'd0, co_v[0]}, 32'd0);
        rst = 1'b0;

        op(0, 8, 32'h00, 32'h00, 1'b0, 32'h00, 1'b0, 16'h0000, 0, "w8_zero");
        op(0, 8, 32'hFF, 32'h01, 1'b0, 32'h00, 1'b1, 16'h0000, 0, "w8_ff_01");
        op(0, 8, 32'hA5, 32'h5A, 1'b1, 32'h00, 1'b1, 16'h0000, 0, "w8_a5_5a_c");
        op(0, 8, 32'h3C, 32'h42, 1'b0, 32'h7E, 1'b0, 16'h0000, 0, "w8_3c_42");
        op(0, 8, 32'h12, 32'h34, 1'b0, 32'h46, 1'b0, 16'h0208, 0, "w8_ignore_start");
        op(0, 8, 32'h77, 32'h11, 1'b1, 32'h00, 1'b0, 16'h0000, 5, "w8_rst_abort");
        op(0, 8, 32'h0F, 32'hF1, 1'b1, 32'h01, 1'b1, 16'h0000, 0, "w8_after_rst");
        back_to_back();

        for (int i = 0; i < 128; i++) begin
            v    = 7'(i);
            sum3 = {1'b0, v[5:3]} + {1'b0, v[2:0]} + {3'd0, v[6]};
            op(1, 3, {29'd0, v[5:3]}, {29'd0, v[2:0]}, v[6], {29'd0, sum3[2:0]}, sum3[3],
               16'h0000, 0, $sformatf("w3_%0d", i));
        end

        op(2, 1, 32'h1, 32'h1, 1'b1, 32'h1, 1'b1, 16'h0000, 0, "w1_111");
        op(2, 1, 32'h1, 32'h0, 1'b0, 32'h1, 1'b0, 16'h0000, 0, "w1_100");
        op(2, 1, 32'h0, 32'h1, 1'b1, 32'h0, 1'b1, 16'h0000, 0, "w1_011");

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
